// File: rtl/apb_master_ctrl_if.sv
// APB master controller bus bundle: local command/response handshake plus APB requester/completer signals.
// Latency: none, wiring only.
// Backpressure: cmd_ready gates command acceptance; the APB side stalls via ready.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

interface apb_master_ctrl_if #(
    parameter int ADDR_WIDTH = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = `APB_DATA_WIDTH
);
    // local command side
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_strb;
    logic [2:0]                cmd_prot;

    // completion response
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_error;

    // APB requester outputs
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      sel;
    logic                      enable;
    logic                      write;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   strb;
    logic [2:0]                prot;

    // APB completer inputs
    logic                      ready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      slave_error;

    // controller view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        output addr, sel, enable, write, wdata, strb, prot,
        input  ready, rdata, slave_error
    );

    // command source / APB completer view
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        input  addr, sel, enable, write, wdata, strb, prot,
        output ready, rdata, slave_error
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master controller: turns one local command into an APB SETUP/ACCESS transfer and a one-cycle response.
// Latency: accept at T, SETUP T+1, ACCESS T+2, response one cycle after ready (T+3 with zero waits).
// Backpressure: cmd_ready high only in IDLE; APB ready=0 holds ACCESS (optional timeout: APB_MASTER_TIMEOUT_EN).
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_master_ctrl #(
    parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_ctrl_if.master   bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_strb;
    logic [2:0]              r_prot;
    logic                    r_sel;
    logic                    r_enable;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_error;

    logic                    w_load_cmd;
    logic                    w_sel_nxt;
    logic                    w_enable_nxt;
    logic                    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
    logic                    w_rsp_error_nxt;
    logic                    w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]        r_wait_cnt;

    // Wait-state counter: held at zero outside ACCESS so it is clear on entry,
    // then counts every ACCESS cycle the completer leaves ready low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_ACCESS) begin
            r_wait_cnt <= '0;
        end else if (!bus.ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // This wait cycle brings the count to the limit; ready=1 in it still completes normally.
    assign w_timeout = (r_state == ST_ACCESS) && !bus.ready &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic                    w_unused_timeout;

    // Without the timeout, ACCESS waits for ready indefinitely.
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the registered control/response outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_cmd      = 1'b0;
        w_sel_nxt       = r_sel;
        w_enable_nxt    = r_enable;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_error_nxt = r_rsp_error;
        case (r_state)
            ST_IDLE: begin
                // cmd_ready is high in IDLE, so cmd_valid alone means acceptance.
                if (bus.cmd_valid) begin
                    w_load_cmd   = 1'b1;
                    w_state_nxt  = ST_SETUP;
                    w_sel_nxt    = 1'b1;
                    w_enable_nxt = 1'b0;
                end
            end
            ST_SETUP: begin
                // SETUP lasts exactly one cycle; ready here is ignored.
                w_state_nxt  = ST_ACCESS;
                w_sel_nxt    = 1'b1;
                w_enable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (bus.ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_sel_nxt       = 1'b0;
                    w_enable_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = bus.slave_error;
                    w_rsp_rdata_nxt = r_write ? '0 : bus.rdata;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_sel_nxt       = 1'b0;
                    w_enable_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_sel_nxt    = 1'b0;
                w_enable_nxt = 1'b0;
            end
        endcase
    end

    // Control strobes and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= 1'b0;
            r_enable    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_sel       <= w_sel_nxt;
            r_enable    <= w_enable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_error <= w_rsp_error_nxt;
        end
    end

    // Transfer fields: captured only on acceptance so they stay stable through ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
        end else if (w_load_cmd) begin
            r_addr  <= bus.cmd_addr;
            r_write <= bus.cmd_write;
            r_wdata <= bus.cmd_wdata;
            r_strb  <= bus.cmd_write ? bus.cmd_strb : '0;
            r_prot  <= bus.cmd_prot;
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.addr      = r_addr;
    assign bus.sel       = r_sel;
    assign bus.enable    = r_enable;
    assign bus.write     = r_write;
    assign bus.wdata     = r_wdata;
    assign bus.strb      = r_strb;
    assign bus.prot      = r_prot;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_error = r_rsp_error;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: reset, zero-wait and wait-state transfers, errors, back-to-back, reset abort.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: ready driven per vector; timeout vectors active when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    apb_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one command in an IDLE cycle; returns in the SETUP cycle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        bus.cmd_prot  = p;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb = '0;
        bus.cmd_prot = '0;
        bus.ready = 1'b0;
        bus.rdata = '0;
        bus.slave_error = 1'b0;
        repeat (2) tick();

        // reset state
        chk("rst_sel", bus.sel, 0);
        chk("rst_enable", bus.enable, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_strb", bus.strb, 0);
        chk("rst_prot", bus.prot, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_error", bus.rsp_error, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        rst = 1'b0;

        // ready/slave_error in IDLE have no effect
        bus.ready = 1'b1;
        bus.slave_error = 1'b1;
        repeat (2) tick();
        chk("idle_ready_sel", bus.sel, 0);
        chk("idle_ready_rsp", bus.rsp_valid, 0);
        bus.ready = 1'b0;
        bus.slave_error = 1'b0;

        // zero-wait write 0x10
        bus.rdata = 32'hFFFF_0000;
        issue(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 3'b010);
        chk("wr_setup_sel", bus.sel, 1);
        chk("wr_setup_en", bus.enable, 0);
        chk("wr_setup_cmd_ready", bus.cmd_ready, 0);
        chk("wr_addr", bus.addr, 32'h10);
        chk("wr_wdata", bus.wdata, 32'hA5A5_5A5A);
        chk("wr_strb", bus.strb, 4'hF);
        chk("wr_write", bus.write, 1);
        chk("wr_prot", bus.prot, 3'b010);
        bus.ready = 1'b1;
        tick();
        chk("wr_access_sel", bus.sel, 1);
        chk("wr_access_en", bus.enable, 1);
        chk("wr_access_rsp", bus.rsp_valid, 0);
        tick();
        chk("wr_done_sel", bus.sel, 0);
        chk("wr_done_en", bus.enable, 0);
        chk("wr_rsp_valid", bus.rsp_valid, 1);
        chk("wr_rsp_error", bus.rsp_error, 0);
        chk("wr_rsp_rdata", bus.rsp_rdata, 0);
        chk("wr_done_cmd_ready", bus.cmd_ready, 1);
        bus.ready = 1'b0;
        tick();
        chk("wr_rsp_one_cycle", bus.rsp_valid, 0);

        // read 0x20, three wait states
        bus.rdata = 32'hDEAD_BEEF;
        bus.slave_error = 1'b1;
        issue(1'b0, 32'h20, 32'h1111_2222, 4'hF, 3'b001);
        for (int i = 0; i < 5; i++) begin
            chk("rd_addr_stable", bus.addr, 32'h20);
            chk("rd_strb", bus.strb, 0);
            chk("rd_enable", bus.enable, (i > 0) ? 1 : 0);
            chk("rd_wait_rsp", bus.rsp_valid, 0);
            if (i == 4) begin
                bus.ready = 1'b1;
                bus.rdata = 32'h1234_5678;
                bus.slave_error = 1'b0;
            end
            tick();
        end
        chk("rd_rsp_valid", bus.rsp_valid, 1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_error", bus.rsp_error, 0);
        bus.ready = 1'b0;
        tick();

        // slave error on completing cycle
        bus.ready = 1'b1;
        bus.slave_error = 1'b1;
        issue(1'b1, 32'h30, 32'h0000_00FF, 4'h1, 3'b000);
        tick();
        tick();
        chk("err_rsp_valid", bus.rsp_valid, 1);
        chk("err_rsp_error", bus.rsp_error, 1);
        bus.ready = 1'b0;
        tick();

        // slave error only during wait states
        issue(1'b1, 32'h34, 32'h0000_0F0F, 4'h3, 3'b000);
        bus.slave_error = 1'b1;
        tick();
        tick();
        chk("werr_wait_en", bus.enable, 1);
        chk("werr_wait_rsp", bus.rsp_valid, 0);
        bus.ready = 1'b1;
        bus.slave_error = 1'b0;
        tick();
        chk("werr_rsp_valid", bus.rsp_valid, 1);
        chk("werr_rsp_error", bus.rsp_error, 0);
        bus.ready = 1'b0;
        tick();

        // three back-to-back commands with cmd_valid held high
        bus.ready = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_wdata = 32'h0BAD_F00D;
        bus.cmd_strb = 4'hF;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if ((c % 3 == 0) && (c < 9)) bus.cmd_addr = 32'h100 + c;
            chk("b2b_cmd_ready", bus.cmd_ready, ((c % 3 == 0) || (c >= 9)) ? 1 : 0);
            chk("b2b_rsp_valid", bus.rsp_valid, ((c == 3) || (c == 6) || (c == 9)) ? 1 : 0);
            chk("b2b_sel", bus.sel, ((c < 9) && (c % 3 != 0)) ? 1 : 0);
            if ((c % 3 == 1) && (c < 9)) chk("b2b_addr", bus.addr, 32'h100 + c - 1);
            if (c == 7) bus.cmd_valid = 1'b0;
            tick();
        end
        bus.ready = 1'b0;

        // reset while a read waits in ACCESS
        bus.rdata = 32'h0000_5555;
        issue(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
        tick();
        tick();
        chk("abort_pre_en", bus.enable, 1);
        rst = 1'b1;
        bus.ready = 1'b1;
        tick();
        chk("abort_sel", bus.sel, 0);
        chk("abort_en", bus.enable, 0);
        chk("abort_rsp", bus.rsp_valid, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_addr", bus.addr, 0);
        rst = 1'b0;
        bus.ready = 1'b0;
        tick();
        chk("abort_post_rsp", bus.rsp_valid, 0);
        chk("abort_post_sel", bus.sel, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        // ready held low: timeout after four wait cycles
        bus.rdata = 32'h0000_0077;
        issue(1'b0, 32'h80, 32'h0, 4'h0, 3'b000);
        repeat (4) tick();
        chk("to_wait_en", bus.enable, 1);
        chk("to_wait_rsp", bus.rsp_valid, 0);
        tick();
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_error", bus.rsp_error, 1);
        chk("to_rsp_rdata", bus.rsp_rdata, 0);
        chk("to_sel", bus.sel, 0);
        chk("to_cmd_ready", bus.cmd_ready, 1);
        tick();

        // ready on the fourth wait cycle completes normally
        issue(1'b0, 32'h84, 32'h0, 4'h0, 3'b000);
        repeat (4) tick();
        bus.ready = 1'b1;
        bus.rdata = 32'hCAFE_F00D;
        tick();
        chk("to_edge_rsp_valid", bus.rsp_valid, 1);
        chk("to_edge_rsp_error", bus.rsp_error, 0);
        chk("to_edge_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        bus.ready = 1'b0;
        tick();
`else
        // without the timeout ACCESS waits indefinitely
        issue(1'b0, 32'h80, 32'h0, 4'h0, 3'b000);
        repeat (20) tick();
        chk("long_wait_en", bus.enable, 1);
        chk("long_wait_rsp", bus.rsp_valid, 0);
        bus.ready = 1'b1;
        bus.rdata = 32'hCAFE_F00D;
        tick();
        chk("long_rsp_valid", bus.rsp_valid, 1);
        chk("long_rsp_error", bus.rsp_error, 0);
        chk("long_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        bus.ready = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
